core_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port data memory between the MIPS32 cores of the multicore processor. Each core's MEM stage raises a request and stalls until the arbiter completes its access. The arbiter then issues exactly one memory operation per grant and returns read data with a one-cycle done pulse. It sits between the per-core MEM stages and the shared data memory inside MultiCore.

---
 rtl/core_mem_arbiter_if.sv | 30 +++
 rtl/core_mem_arbiter.sv | 96 +++++++++
 tb/tb_core_mem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_if.sv
// Bus bundle between the per-core MEM stages, core_mem_arbiter and the shared data memory.
// master: the arbiter side. slave: the cores and memory side.
interface core_mem_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) ();
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_we;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_stall;
    logic [NUM_CORES-1:0]        core_done;
    logic [DATA_W-1:0]           core_rdata;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    modport master (
        input  core_req, core_we, core_addr, core_wdata, mem_rdata,
        output core_stall, core_done, core_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output core_req, core_we, core_addr, core_wdata, mem_rdata,
        input  core_stall, core_done, core_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter granting one shared single-port data memory to one core at a time.
// state | meaning
// IDLE  | pick next requester from rr_ptr, latch its request
// ISSUE | mem_en pulse with the latched request
// WAIT  | count down memory latency, capture load data
// RESP  | core_done pulse, advance rr_ptr
module core_mem_arbiter #(
    parameter int NUM_CORES   = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    core_mem_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic [CNT_W-1:0] wait_cnt;
    logic             pick_valid;
    logic [IDX_W-1:0] pick;

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_CORES;
            if (bus.core_req[idx]) begin
                pick_valid = 1'b1;
                pick       = IDX_W'(idx);
            end
        end
    end

    assign bus.core_stall = bus.core_req & ~bus.core_done;

    // mem_we/mem_addr/mem_wdata double as the latched request, so later core-side changes are ignored.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant          <= '0;
            wait_cnt       <= '0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.core_done  <= '0;
            bus.core_rdata <= '0;
        end else begin
            bus.mem_en    <= 1'b0;
            bus.core_done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant         <= pick;
                        bus.mem_we    <= bus.core_we[pick];
                        bus.mem_addr  <= bus.core_addr[int'(pick)*ADDR_W +: ADDR_W];
                        bus.mem_wdata <= bus.core_wdata[int'(pick)*DATA_W +: DATA_W];
                        bus.mem_en    <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= CNT_W'(MEM_LATENCY - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        if (!bus.mem_we) begin
                            bus.core_rdata <= bus.mem_rdata;
                        end
                        bus.core_done[grant] <= 1'b1;
                        state                <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (int'(grant) == NUM_CORES - 1) ? '0 : grant + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level timing/round-robin model.
module tb_core_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 1;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [31:0] exp_rd_dir = 32'h0;

    always #5 Clk = ~Clk;

    core_mem_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus.master)
    );

    // Shared data memory: L-cycle read latency, write on the mem_en edge.
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] rd_pipe [L];
    always @(posedge Clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
            else rd_pipe[0] <= env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : 32'h0;
        end
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[L-1];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_core(input int c, input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.core_req[c]            = req;
        bus.core_we[c]             = we;
        bus.core_addr[c*AW +: AW]  = a;
        bus.core_wdata[c*DW +: DW] = d;
    endtask

    task automatic clear_all();
        bus.core_req   = '0;
        bus.core_we    = '0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
    endtask

    task automatic idle(input int n);
        clear_all();
        repeat (n) tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Issues one request from the current (idle) cycle and follows it to core_done.
    task automatic do_access(input int c, input logic we, input logic [31:0] a, input logic [31:0] d,
                             output int lat, output int en_cnt, output int we_cnt, output logic [31:0] rd);
        lat = -1; en_cnt = 0; we_cnt = 0; rd = 32'h0;
        set_core(c, 1'b1, we, a, d);
        for (int k = 0; k < 40; k++) begin
            if (bus.mem_en) begin
                en_cnt++;
                if (bus.mem_we) we_cnt++;
            end
            if (bus.core_done[c]) begin
                lat = k;
                rd  = bus.core_rdata;
                tick();
                break;
            end
            tick();
        end
        set_core(c, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        clear_all();
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 32'h100 + 4*i, 32'h0);
        Reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (bus.mem_en !== 1'b0 || bus.core_done !== '0 || bus.core_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: mem_en=%b done=%b rdata=%h, required 0 0 0", k, bus.mem_en, bus.core_done, bus.core_rdata);
            end
        end
        Reset = 1'b0;
        #1;
        n_tests++;
        if (bus.mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: mem_en=%b, required 0", bus.mem_en);
        end
        tick();
        n_tests++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL reset_first_grant: mem_en=%b addr=%h, required 1 00000100", bus.mem_en, bus.mem_addr);
        end
        idle(6);
    endtask

    task automatic test_single_load();
        env_mem[32'h40] = 32'hDEADBEEF;
        clear_all();
        set_core(2, 1'b1, 1'b0, 32'h40, 32'h0);
        #1;
        n_tests++;
        if (bus.core_stall[2] !== 1'b1 || bus.mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL load_c0: stall2=%b mem_en=%b, required 1 0", bus.core_stall[2], bus.mem_en);
        end
        tick();
        n_tests++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0 || bus.core_stall[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL load_c1: en=%b addr=%h we=%b stall2=%b, required 1 00000040 0 1", bus.mem_en, bus.mem_addr, bus.mem_we, bus.core_stall[2]);
        end
        tick();
        n_tests++;
        if (bus.mem_en !== 1'b0 || bus.core_stall[2] !== 1'b1 || bus.core_done !== 4'b0000) begin
            n_fail++;
            $display("FAIL load_c2: en=%b stall2=%b done=%b, required 0 1 0000", bus.mem_en, bus.core_stall[2], bus.core_done);
        end
        tick();
        n_tests++;
        if (bus.core_done !== 4'b0100 || bus.core_rdata !== 32'hDEADBEEF || bus.core_stall[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_c3: done=%b rdata=%h stall2=%b, required 0100 deadbeef 0", bus.core_done, bus.core_rdata, bus.core_stall[2]);
        end
        exp_rd_dir = 32'hDEADBEEF;
        tick();
        idle(2);
    endtask

    task automatic test_wrap_priority();
        int  order[$];
        bit  dropn[N];
        env_mem[32'h100] = 32'h0A0A0A0A;
        env_mem[32'h10C] = 32'h3C3C3C3C;
        clear_all();
        set_core(0, 1'b1, 1'b0, 32'h100, 32'h0);
        set_core(3, 1'b1, 1'b0, 32'h10C, 32'h0);
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) if (dropn[i]) begin bus.core_req[i] = 1'b0; dropn[i] = 1'b0; end
            if (bus.mem_en) order.push_back(int'(bus.mem_addr - 32'h100) / 4);
            for (int i = 0; i < N; i++) if (bus.core_done[i]) dropn[i] = 1'b1;
            tick();
        end
        n_tests++;
        if (order.size() != 2) begin
            n_fail++;
            $display("FAIL wrap_count: grants=%0d, required 2", order.size());
        end else begin
            n_tests++;
            if (order[0] != 3 || order[1] != 0) begin
                n_fail++;
                $display("FAIL wrap_order: %0d,%0d, required 3,0", order[0], order[1]);
            end
        end
        exp_rd_dir = 32'h0A0A0A0A;
        idle(2);
    endtask

    task automatic test_single_store();
        int lat, en_cnt, we_cnt;
        logic [31:0] rd;
        clear_all();
        do_access(1, 1'b1, 32'h80, 32'h12345678, lat, en_cnt, we_cnt, rd);
        n_tests++;
        if (lat != 2 + L || en_cnt != 1 || we_cnt != 1) begin
            n_fail++;
            $display("FAIL store_strobe: lat=%0d en=%0d we=%0d, required %0d 1 1", lat, en_cnt, we_cnt, 2 + L);
        end
        n_tests++;
        if (rd !== exp_rd_dir) begin
            n_fail++;
            $display("FAIL store_rdata_kept: rdata=%h, required %h", rd, exp_rd_dir);
        end
        do_access(0, 1'b0, 32'h80, 32'h0, lat, en_cnt, we_cnt, rd);
        n_tests++;
        if (lat != 2 + L || rd !== 32'h12345678 || we_cnt != 0) begin
            n_fail++;
            $display("FAIL store_readback: lat=%0d rdata=%h we=%0d, required %0d 12345678 0", lat, rd, we_cnt, 2 + L);
        end
        idle(2);
    endtask

    task automatic test_round_robin();
        int cores[$];
        int cycs[$];
        clear_all();
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 32'h100 + 4*i, 32'h0);
        do_reset();
        for (int k = 0; k < 60 && cores.size() < 6; k++) begin
            if (bus.mem_en) begin
                cores.push_back(int'(bus.mem_addr - 32'h100) / 4);
                cycs.push_back(k);
            end
            tick();
        end
        n_tests++;
        if (cores.size() != 6) begin
            n_fail++;
            $display("FAIL rr_count: grants=%0d, required 6", cores.size());
        end
        for (int j = 0; j < cores.size(); j++) begin
            n_tests++;
            if (cores[j] != j % N) begin
                n_fail++;
                $display("FAIL rr_order grant%0d: core %0d, required %0d", j, cores[j], j % N);
            end
            if (j > 0) begin
                n_tests++;
                if (cycs[j] - cycs[j-1] != 3 + L) begin
                    n_fail++;
                    $display("FAIL rr_spacing grant%0d: gap %0d, required %0d", j, cycs[j] - cycs[j-1], 3 + L);
                end
            end
        end
        idle(8);
    endtask

    task automatic test_abort_reset_wait();
        clear_all();
        set_core(1, 1'b1, 1'b0, 32'h104, 32'h0);
        tick();
        n_tests++;
        if (bus.mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_rst_issue: mem_en=%b, required 1", bus.mem_en);
        end
        tick();
        Reset = 1'b1;
        tick();
        n_tests++;
        if (bus.core_done !== '0 || bus.mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_rst_nodone: done=%b mem_en=%b, required 0000 0", bus.core_done, bus.mem_en);
        end
        Reset = 1'b0;
        tick();
        n_tests++;
        if (bus.mem_en !== 1'b1 || bus.core_done !== '0) begin
            n_fail++;
            $display("FAIL abort_rst_idle: mem_en=%b done=%b, required 1 0000", bus.mem_en, bus.core_done);
        end
        idle(8);
    endtask

    task automatic test_abort_req_drop();
        int lat, en_cnt, we_cnt;
        logic [31:0] rd;
        clear_all();
        set_core(2, 1'b1, 1'b1, 32'hC0, 32'hA5A50001);
        tick();
        set_core(2, 1'b0, 1'b0, 32'hFFC, 32'hBAD0BAD0);
        #1;
        n_tests++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'hC0 || bus.mem_wdata !== 32'hA5A50001) begin
            n_fail++;
            $display("FAIL drop_issue: en=%b we=%b addr=%h wdata=%h, required 1 1 000000c0 a5a50001", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        tick();
        n_tests++;
        if (bus.core_done !== 4'b0100 || bus.core_stall !== 4'b0000) begin
            n_fail++;
            $display("FAIL drop_done: done=%b stall=%b, required 0100 0000", bus.core_done, bus.core_stall);
        end
        idle(2);
        do_access(0, 1'b0, 32'hC0, 32'h0, lat, en_cnt, we_cnt, rd);
        n_tests++;
        if (rd !== 32'hA5A50001) begin
            n_fail++;
            $display("FAIL drop_readback: rdata=%h, required a5a50001", rd);
        end
        idle(2);
    endtask

    // Model: an access granted in an idle cycle c strobes at c+1, completes at c+2+L, frees at c+3+L.
    task automatic test_random();
        logic [31:0] mmem [logic [31:0]];
        bit          pend[N];
        bit          dropn[N];
        logic        pwe[N];
        logic [31:0] pa[N];
        logic [31:0] pd[N];
        int          next_idle = 0, rr = 0, cur_g = 0, gsel, en_cyc = -1, done_cyc = -1;
        logic        gwe = 1'b0;
        logic [31:0] ga = 32'h0, gd = 32'h0, grd = 32'h0, exp_rd = 32'h0;
        logic [N-1:0] req_v, exp_done;
        for (int i = 0; i < N; i++) begin pwe[i] = 1'b0; pa[i] = 32'h0; pd[i] = 32'h0; end
        clear_all();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (dropn[i]) begin pend[i] = 1'b0; dropn[i] = 1'b0; end
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pwe[i]  = 1'($urandom_range(0, 1));
                    pa[i]   = 32'h200 + 32'(4 * $urandom_range(0, 7));
                    pd[i]   = $urandom;
                end
                set_core(i, pend[i], pwe[i], pa[i], pd[i]);
                req_v[i] = pend[i];
            end
            if (cyc >= next_idle) begin
                gsel = -1;
                for (int k = 0; k < N; k++) if (gsel < 0 && pend[(rr + k) % N]) gsel = (rr + k) % N;
                if (gsel >= 0) begin
                    cur_g = gsel;
                    en_cyc = cyc + 1; done_cyc = cyc + 2 + L; next_idle = cyc + 3 + L;
                    gwe = pwe[gsel]; ga = pa[gsel]; gd = pd[gsel];
                    if (gwe) mmem[ga] = gd;
                    else grd = mmem.exists(ga) ? mmem[ga] : 32'h0;
                end
            end
            #1;
            exp_done = '0;
            if (cyc == done_cyc) begin
                exp_done[cur_g] = 1'b1;
                if (!gwe) exp_rd = grd;
            end
            n_tests++;
            if (bus.mem_en !== (cyc == en_cyc)) begin
                n_fail++;
                $display("FAIL rnd_mem_en cyc%0d: %b, required %b", cyc, bus.mem_en, cyc == en_cyc);
            end
            if (cyc == en_cyc) begin
                n_tests++;
                if (bus.mem_addr !== ga || bus.mem_we !== gwe || (gwe && bus.mem_wdata !== gd)) begin
                    n_fail++;
                    $display("FAIL rnd_access cyc%0d: addr=%h we=%b wdata=%h, required %h %b %h", cyc, bus.mem_addr, bus.mem_we, bus.mem_wdata, ga, gwe, gd);
                end
            end
            n_tests++;
            if (bus.core_done !== exp_done) begin
                n_fail++;
                $display("FAIL rnd_done cyc%0d: %b, required %b", cyc, bus.core_done, exp_done);
            end
            n_tests++;
            if (bus.core_rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL rnd_rdata cyc%0d: %h, required %h", cyc, bus.core_rdata, exp_rd);
            end
            n_tests++;
            if (bus.core_stall !== (req_v & ~exp_done)) begin
                n_fail++;
                $display("FAIL rnd_stall cyc%0d: %b, required %b", cyc, bus.core_stall, req_v & ~exp_done);
            end
            if (cyc == done_cyc) begin
                dropn[cur_g] = 1'b1;
                rr = (cur_g + 1) % N;
            end
            tick();
        end
        idle(8);
    endtask

    initial begin
        clear_all();
        test_reset();
        test_single_load();
        test_wrap_priority();
        test_single_store();
        test_round_robin();
        test_abort_reset_wait();
        test_abort_req_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
